// File: rtl/serdes_pkg.sv
// serdes_pkg: shared FSM states, training word and nibble-alignment helper for the serial receive path
package serdes_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CAL, ST_SETTLE, ST_SEARCH, ST_LOCKED} state_t;
  localparam logic [63:0] TRAIN_PATTERN = 64'hF0E1_D2C3_B4A5_9687;
  function automatic logic [63:0] nib_align(input logic [127:0] cat, input logic [3:0] ofs);
    return cat[{ofs, 2'b00} +: 64];
  endfunction
endpackage

// File: rtl/nib_aligner.sv
// nib_aligner: previous-word register, 16:1 nibble mux and registered aligned-word output
module nib_aligner
  import serdes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_word,
  input  logic        i_vld,
  input  logic [3:0]  i_ofs,
  input  logic        i_keep,
  output logic [63:0] o_aligned,
  output logic [63:0] o_aword,
  output logic        o_aword_vld
);
  logic [63:0] r_prev;
  logic [63:0] r_aword;
  logic        r_aword_vld;
  logic        w_cap;
  assign o_aligned   = nib_align({r_prev, i_word}, i_ofs);
  assign w_cap       = i_vld & i_keep;
  assign o_aword     = r_aword;
  assign o_aword_vld = r_aword_vld;
  // aligned word is held between strobes only while lock persists
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_aword     <= '0;
      r_aword_vld <= 1'b0;
    end else begin
      r_prev      <= i_vld ? i_word : r_prev;
      r_aword     <= w_cap ? o_aligned : (i_keep ? r_aword : '0);
      r_aword_vld <= w_cap;
    end
  end
endmodule

// File: rtl/serial_align_ctrl.sv
// serial_align_ctrl: IODELAY calibration, nibble-offset search, lock tracking and stream realignment
module serial_align_ctrl
  import serdes_pkg::*;
#(
  parameter int CAL_CYC    = 16,
  parameter int SETTLE_CYC = 256,
  parameter int MATCH_NEED = 8,
  parameter int LOSS_LIM   = 4,
  parameter int MAX_SWEEP  = 4
) (
  input  logic        CLKS,
  input  logic        RSTS,
  input  logic        START,
  input  logic        TRAIN,
  input  logic [63:0] WORD,
  input  logic        WORD_VLD,
  output logic        PHY_INIT,
  output logic        LOCKED,
  output logic [3:0]  ALIGN,
  output logic [63:0] AWORD,
  output logic        AWORD_VLD,
  output logic        CAL_FAIL
);
  localparam int CW = $clog2(CAL_CYC + 1);
  localparam int SW_ = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MATCH_NEED + 1);
  localparam int LW = $clog2(LOSS_LIM + 1);
  localparam int PW = $clog2(MAX_SWEEP + 1);
  state_t        r_state, w_state;
  logic [CW-1:0] r_ccnt, w_ccnt;
  logic [SW_-1:0] r_scnt, w_scnt;
  logic [MW-1:0] r_mcnt, w_mcnt;
  logic [LW-1:0] r_lcnt, w_lcnt;
  logic [PW-1:0] r_sweep, w_sweep;
  logic [3:0]    r_align, w_align;
  logic          r_fail, w_fail;
  logic          w_step;
  logic          w_keep;
  logic          w_match;
  logic [63:0]   w_aligned;
  nib_aligner u_aligner (
    .clk        (CLKS),
    .rst        (RSTS),
    .i_word     (WORD),
    .i_vld      (WORD_VLD),
    .i_ofs      (r_align),
    .i_keep     (w_keep),
    .o_aligned  (w_aligned),
    .o_aword    (AWORD),
    .o_aword_vld(AWORD_VLD)
  );
  assign w_match  = w_aligned == TRAIN_PATTERN;
  assign w_keep   = (r_state == ST_LOCKED) && (w_state == ST_LOCKED);
  assign PHY_INIT = r_state == ST_CAL;
  assign LOCKED   = r_state == ST_LOCKED;
  assign ALIGN    = r_align;
  assign CAL_FAIL = r_fail;
  always_comb begin
    w_state = r_state;
    w_ccnt  = '0;
    w_scnt  = '0;
    w_mcnt  = r_mcnt;
    w_lcnt  = '0;
    w_sweep = r_sweep;
    w_fail  = r_fail;
    w_step  = 1'b0;
    case (r_state)
      ST_IDLE: w_state = ST_CAL;
      ST_CAL: begin
        w_ccnt  = (r_ccnt == CW'(CAL_CYC - 1)) ? '0 : r_ccnt + 1'b1;
        w_state = (r_ccnt == CW'(CAL_CYC - 1)) ? ST_SETTLE : ST_CAL;
      end
      ST_SETTLE: begin
        w_mcnt  = '0;
        w_scnt  = (r_scnt == SW_'(SETTLE_CYC - 1)) ? '0 : r_scnt + 1'b1;
        w_state = (r_scnt == SW_'(SETTLE_CYC - 1)) ? ST_SEARCH : ST_SETTLE;
      end
      ST_SEARCH: begin
        if (WORD_VLD && w_match) begin
          w_mcnt = r_mcnt + 1'b1;
          if (w_mcnt == MW'(MATCH_NEED)) begin
            w_state = ST_LOCKED;
            w_sweep = '0;
          end
        end else if (WORD_VLD) begin
          w_mcnt = '0;
          w_step = 1'b1;
          // offset wrap closes one sweep; too many sweeps forces recalibration
          if (r_align == 4'hF) begin
            w_sweep = (r_sweep == PW'(MAX_SWEEP - 1)) ? '0 : r_sweep + 1'b1;
            w_fail  = r_fail | (r_sweep == PW'(MAX_SWEEP - 1));
            w_state = (r_sweep == PW'(MAX_SWEEP - 1)) ? ST_CAL : ST_SEARCH;
          end
        end
      end
      ST_LOCKED: begin
        w_lcnt  = !TRAIN ? '0 : (!WORD_VLD ? r_lcnt : (w_match ? '0 : r_lcnt + 1'b1));
        w_state = (w_lcnt == LW'(LOSS_LIM)) ? ST_CAL : ST_LOCKED;
      end
      default: w_state = ST_IDLE;
    endcase
    if (!START) begin
      w_state = ST_IDLE;
      w_sweep = '0;
    end
    w_align = (w_state == ST_SEARCH || w_state == ST_LOCKED) ? r_align + {3'b000, w_step} : 4'h0;
  end
  always_ff @(posedge CLKS) begin
    if (RSTS) begin
      r_state <= ST_IDLE;
      r_ccnt  <= '0;
      r_scnt  <= '0;
      r_mcnt  <= '0;
      r_lcnt  <= '0;
      r_sweep <= '0;
      r_align <= '0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ccnt  <= w_ccnt;
      r_scnt  <= w_scnt;
      r_mcnt  <= w_mcnt;
      r_lcnt  <= w_lcnt;
      r_sweep <= w_sweep;
      r_align <= w_align;
      r_fail  <= w_fail;
    end
  end
endmodule

// File: tb/tb_serial_align_ctrl.sv
// tb_serial_align_ctrl: directed bring-up scenarios checked every cycle against a behavioural model
module tb_serial_align_ctrl;
  localparam logic [63:0] PAT = 64'hF0E1_D2C3_B4A5_9687;
  localparam int CAL = 16, SETTLE = 256, MATCH = 8, LOSS = 4, MAXS = 4;
  logic        CLKS = 0, RSTS = 1, START = 0, TRAIN = 0, WORD_VLD = 0;
  logic [63:0] WORD = '0;
  logic        PHY_INIT, LOCKED, AWORD_VLD, CAL_FAIL;
  logic [3:0]  ALIGN;
  logic [63:0] AWORD;
  int n_cmp = 0, n_bad = 0;
  logic chk = 0;
  int m_ph = 0, m_left = 0, m_align = 0, m_hits = 0, m_miss = 0, m_sw = 0;
  logic m_fail = 0, m_avld = 0;
  logic [63:0] m_aword = '0, m_prev = '0;
  int run = 0, plen = 0;

  serial_align_ctrl dut (
    .CLKS(CLKS), .RSTS(RSTS), .START(START), .TRAIN(TRAIN), .WORD(WORD), .WORD_VLD(WORD_VLD),
    .PHY_INIT(PHY_INIT), .LOCKED(LOCKED), .ALIGN(ALIGN), .AWORD(AWORD), .AWORD_VLD(AWORD_VLD),
    .CAL_FAIL(CAL_FAIL)
  );

  always #5 CLKS = ~CLKS;

  function automatic logic [63:0] rol(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // phases: 0 idle, 1 calibrate, 2 settle, 3 search, 4 locked
  always @(posedge CLKS) begin : mdl
    int ph, left, al, hits, miss, sw;
    logic fail, av;
    logic [63:0] a, aw;
    ph = m_ph; left = m_left; al = m_align; hits = m_hits; miss = m_miss; sw = m_sw;
    fail = m_fail; av = 0; aw = m_aword;
    a = 64'({m_prev, WORD} >> (4 * m_align));
    if (RSTS) begin
      ph = 0; left = 0; al = 0; hits = 0; miss = 0; sw = 0; fail = 0; aw = '0;
    end else if (!START) begin
      ph = 0; sw = 0;
    end else if (ph == 0) begin
      ph = 1; left = CAL;
    end else if (ph == 1) begin
      left = left - 1;
      if (left == 0) begin ph = 2; left = SETTLE; end
    end else if (ph == 2) begin
      left = left - 1;
      if (left == 0) begin ph = 3; hits = 0; end
    end else if (ph == 3 && WORD_VLD) begin
      if (a == PAT) begin
        hits = hits + 1;
        if (hits == MATCH) begin ph = 4; miss = 0; sw = 0; end
      end else begin
        hits = 0; al = (al + 1) % 16;
        if (al == 0) begin
          sw = sw + 1;
          if (sw == MAXS) begin fail = 1; sw = 0; ph = 1; left = CAL; end
        end
      end
    end else if (ph == 4) begin
      if (!TRAIN) miss = 0;
      else if (WORD_VLD) miss = (a == PAT) ? 0 : miss + 1;
      if (miss == LOSS) begin ph = 1; left = CAL; miss = 0; end
      else if (WORD_VLD) begin av = 1; aw = a; end
    end
    if (ph != 3 && ph != 4) al = 0;
    m_ph <= ph; m_left <= left; m_align <= al; m_hits <= hits; m_miss <= miss; m_sw <= sw;
    m_fail <= fail; m_avld <= av; m_aword <= aw;
    m_prev <= RSTS ? '0 : (WORD_VLD ? WORD : m_prev);
  end

  always @(negedge CLKS) begin
    if (chk) begin
      n_cmp++;
      if ({PHY_INIT, LOCKED, ALIGN, AWORD_VLD, CAL_FAIL} !==
          {m_ph == 1, m_ph == 4, 4'(m_align), m_avld, m_fail} || (m_avld && AWORD !== m_aword)) begin
        n_bad++;
        $display("FAIL model t=%0t: got init=%b lock=%b align=%0d avld=%b fail=%b aword=%h want init=%b lock=%b align=%0d avld=%b fail=%b aword=%h",
                 $time, PHY_INIT, LOCKED, ALIGN, AWORD_VLD, CAL_FAIL, AWORD,
                 m_ph == 1, m_ph == 4, m_align, m_avld, m_fail, m_aword);
      end
    end
    if (PHY_INIT) run <= run + 1;
    else if (run != 0) begin plen <= run; run <= 0; end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] w);
    WORD = w; WORD_VLD = 1;
    @(negedge CLKS);
    WORD_VLD = 0;
  endtask

  task automatic lock_on(input logic [63:0] w, input int budget);
    for (int i = 0; i < budget && !LOCKED; i++) send(w);
    check("lock_reached", 64'(LOCKED), 64'd1);
  endtask

  task automatic reset_dut();
    @(negedge CLKS); RSTS = 1; START = 0;
    @(negedge CLKS); RSTS = 0;
  endtask

  task automatic wait_phy_done();
    int t = 0;
    while (!PHY_INIT && t < 100) begin @(negedge CLKS); t++; end
    while (PHY_INIT && t < 100) begin @(negedge CLKS); t++; end
    check("phy_pulse_done", 64'(t < 100), 64'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge CLKS);
    chk = 1;
    check("rst_outs", 64'({PHY_INIT, LOCKED, ALIGN, AWORD_VLD, CAL_FAIL}), 64'd0);
    // 1: offset 5 stream
    RSTS = 0; START = 1; TRAIN = 1;
    lock_on(rol(PAT, 20), 400);
    check("t1_align", 64'(ALIGN), 64'd5);
    check("t1_plen", 64'(plen), 64'd16);
    send(rol(PAT, 20));
    check("t1_aword", AWORD, PAT);
    check("t1_avld", 64'(AWORD_VLD), 64'd1);
    // 2: offset 0, count strobes in search
    reset_dut();
    START = 1;
    wait_phy_done();
    repeat (260) @(negedge CLKS);
    n = 0;
    while (!LOCKED && n < 20) begin send(PAT); n++; end
    check("t2_strobes", 64'(n), 64'd8);
    check("t2_align", 64'(ALIGN), 64'd0);
    // 4: loss tolerance
    for (int i = 0; i < 3; i++) send(PAT ^ 64'd1);
    send(PAT);
    check("t4_hold", 64'(LOCKED), 64'd1);
    for (int i = 0; i < 4; i++) send(PAT ^ 64'd1);
    check("t4_drop", 64'(LOCKED), 64'd0);
    check("t4_recal", 64'(PHY_INIT), 64'd1);
    // 5: no training, arbitrary data
    lock_on(PAT, 400);
    TRAIN = 0;
    for (int i = 0; i < 10; i++) begin
      send({$urandom, $urandom});
      check("t5_avld_hi", 64'(AWORD_VLD), 64'd1);
      @(negedge CLKS);
      check("t5_avld_lo", 64'(AWORD_VLD), 64'd0);
    end
    check("t5_locked", 64'(LOCKED), 64'd1);
    // 3: random data exhausts sweeps
    reset_dut();
    START = 1; TRAIN = 1;
    for (int i = 0; i < 600 && !CAL_FAIL; i++) send({$urandom, $urandom});
    check("t3_fail", 64'(CAL_FAIL), 64'd1);
    check("t3_recal", 64'(PHY_INIT), 64'd1);
    check("t3_align", 64'(ALIGN), 64'd0);
    // 6: reset mid-calibration, then START drop mid-search
    repeat (5) @(negedge CLKS);
    RSTS = 1;
    @(negedge CLKS);
    check("t6_rst", 64'({PHY_INIT, LOCKED, ALIGN, AWORD_VLD, CAL_FAIL}), 64'd0);
    RSTS = 0;
    wait_phy_done();
    repeat (260) @(negedge CLKS);
    send(PAT ^ 64'd1);
    send(PAT ^ 64'd1);
    check("t6_align", 64'(ALIGN), 64'd2);
    START = 0;
    @(negedge CLKS);
    check("t6_stop", 64'({PHY_INIT, LOCKED, ALIGN, AWORD_VLD, CAL_FAIL}), 64'd0);
    repeat (3) @(negedge CLKS);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
